bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master AXI4-style arbiter for the NPC core. It shares one memory between two masters:
- master 1: instruction-fetch unit, read-only.
- master 2: load/store unit, read and write.

The slave side is internal. Memory is reached through the DPI-C imports `pmem_read(addr, rdata)` and `pmem_write(addr, wdata, wmask)`. Completion pulses go back to the pipeline: `inst_update` for fetches and `mem_finish` for data accesses.

## Interface
Parameters: none; data width fixed at 64, address width at 32.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- araddr_1 / araddr_2  in  32  read address
- arvalid_1 / arvalid_2  in  1  read-address valid
- arburst_1 / arburst_2  in  2  burst type; treated as INCR regardless of value
- arlen_1 / arlen_2  in  8  beats minus one
- arsize_1 / arsize_2  in  3  ignored; every beat is 8 bytes
- arready_1 / arready_2  out  1  read-address ready
- rdata_1 / rdata_2  out  64  read data; 0 when that port's rvalid is low
- rresp_1 / rresp_2  out  2  always 2'b00 (OKAY)
- rvalid_1 / rvalid_2, rlast_1 / rlast_2  out  1  read beat valid / last beat
- rready_1 / rready_2  in  1  read-data ready
- awaddr_2  in  32; awvalid_2  in  1; awburst_2  in  2; awlen_2  in  8; awready_2  out  1  write-address channel
- wdata_2  in  64; wstrb_2  in  8; wlast_2  in  1; wvalid_2  in  1; wready_2  out  1  write-data channel
- bresp_2  out  2 (always 2'b00); bvalid_2  out  1; bready_2  in  1  write-response channel
- inst_update  out  1  one-cycle pulse: master-1 read completed
- mem_finish  out  1  one-cycle pulse: master-2 read or write completed

## Operation
- FSM states: IDLE, RD1, RD2, WDATA, WRESP.
- Grant happens only in IDLE. There is no preemption.
- Priority: awvalid_2 > arvalid_2 > arvalid_1.
- IDLE ready signals (combinational):
  - awready_2 = awvalid_2.
  - arready_2 = arvalid_2 & ~awvalid_2.
  - arready_1 = arvalid_1 & ~arvalid_2 & ~awvalid_2.
  - All readys are 0 outside IDLE.
- AR handshake: latch the address aligned down to 8 (addr & ~7) and the length; go to RD1 or RD2.
- RDx:
  - Each beat calls `pmem_read(addr)` and registers the data onto rdata_x with rvalid_x=1.
  - A beat is held stable until rready_x.
  - On handshake: addr += 8, beat counter increments.
  - rlast_x is high on beat arlen.
  - Handshake on the last beat: go to IDLE.
- AW handshake: latch the aligned address; go to WDATA.
- WDATA:
  - wready_2 = 1.
  - Each wvalid_2 beat calls `pmem_write(addr, wdata_2, wstrb_2)`, then addr += 8.
  - The beat with wlast_2 moves to WRESP.
- WRESP: bvalid_2 = 1 until bready_2, then go to IDLE.
- Completion pulses:
  - Final R handshake on port 1 → inst_update=1 for exactly the next cycle.
  - Final R handshake on port 2 → mem_finish=1 for exactly the next cycle.
  - B handshake → mem_finish=1 for exactly the next cycle.
- Address increment wraps modulo 2^32.

## Timing
- AR or AW handshake in cycle N: first rvalid at N+1; wready_2 from N+1.
- Minimum single-beat read: handshake at N, data at N+1. If rready is held high, the state returns to IDLE at N+2 and the pulse is also at N+2.
- Minimum single-beat write: AW at N, W at N+1, B at N+2.
- Back-pressure: a low rready/bready holds the state and all output values.
- Simultaneous requests in IDLE: only the winner sees ready. Losers stay pending and are re-arbitrated in the next IDLE cycle.
- Reset asserted (rst low) at any time:
  - Immediately: state IDLE, counters and address 0, every output 0.
  - An in-flight transfer is dropped, with no further DPI calls and no pulse.

## Structure
- Shared package: FSM state enum; constant OKAY=2'b00; BEAT_BYTES=8.
- Natural sub-module: `pmem_port`. It wraps the DPI imports, taking one read/write request per cycle.
- Everything else is one FSM plus datapath registers.

## Test plan
- Master 1 only, araddr_1=0x80000004, arlen=0, rready held 1 → arready_1 same cycle; rdata_1 = mem[0x80000000] with rlast_1=1 next cycle; inst_update pulses once; rresp_1=0.
- arvalid_1 and arvalid_2 asserted in the same cycle → port 2 granted first; port 1 gets its ready only after mem_finish; both return correct data.
- awvalid_2 and arvalid_2 together: write 0x1122334455667788 with wstrb=0x0F to 0x80001000 → write wins; bvalid_2 two cycles after AW; the following read returns the low 4 bytes updated only.
- Burst read on port 2, arlen=3, rready toggled 1/0 → 4 beats at +0, +8, +16, +24; data held while rready=0; rlast only on beat 3; one mem_finish.
- rst driven low in RD1 mid-beat → outputs 0 immediately; after release a new fetch completes normally with a single inst_update.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-master memory arbiter
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    WDATA = 3'd3,
    WRESP = 3'd4
  } state_t;

  localparam logic [1:0] OKAY           = 2'b00;
  localparam int         BEAT_BYTES     = 8;
  // Backing store depth in 64-bit words (addr[12:3] selects the word).
  localparam int         MEM_WORDS_LOG2 = 10;

  // Every beat is a full 8-byte word, so addresses are forced onto a beat boundary.
  function automatic logic [31:0] align_beat(input logic [31:0] a);
    return a & ~32'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - AXI4-style channels of both masters, grouped for the arbiter ports
interface bus_arbiter_if;
  // master 1: instruction fetch, read only
  logic [31:0] araddr_1;
  logic        arvalid_1;
  logic [1:0]  arburst_1;
  logic [7:0]  arlen_1;
  logic [2:0]  arsize_1;
  logic        arready_1;
  logic [63:0] rdata_1;
  logic [1:0]  rresp_1;
  logic        rvalid_1;
  logic        rlast_1;
  logic        rready_1;
  // master 2: load/store, read and write
  logic [31:0] araddr_2;
  logic        arvalid_2;
  logic [1:0]  arburst_2;
  logic [7:0]  arlen_2;
  logic [2:0]  arsize_2;
  logic        arready_2;
  logic [63:0] rdata_2;
  logic [1:0]  rresp_2;
  logic        rvalid_2;
  logic        rlast_2;
  logic        rready_2;
  logic [31:0] awaddr_2;
  logic        awvalid_2;
  logic [1:0]  awburst_2;
  logic [7:0]  awlen_2;
  logic        awready_2;
  logic [63:0] wdata_2;
  logic [7:0]  wstrb_2;
  logic        wlast_2;
  logic        wvalid_2;
  logic        wready_2;
  logic [1:0]  bresp_2;
  logic        bvalid_2;
  logic        bready_2;

  modport slave (
    input  araddr_1, arvalid_1, arburst_1, arlen_1, arsize_1, rready_1,
    output arready_1, rdata_1, rresp_1, rvalid_1, rlast_1,
    input  araddr_2, arvalid_2, arburst_2, arlen_2, arsize_2, rready_2,
    output arready_2, rdata_2, rresp_2, rvalid_2, rlast_2,
    input  awaddr_2, awvalid_2, awburst_2, awlen_2,
    output awready_2,
    input  wdata_2, wstrb_2, wlast_2, wvalid_2,
    output wready_2,
    input  bready_2,
    output bresp_2, bvalid_2
  );

  modport master (
    output araddr_1, arvalid_1, arburst_1, arlen_1, arsize_1, rready_1,
    input  arready_1, rdata_1, rresp_1, rvalid_1, rlast_1,
    output araddr_2, arvalid_2, arburst_2, arlen_2, arsize_2, rready_2,
    input  arready_2, rdata_2, rresp_2, rvalid_2, rlast_2,
    output awaddr_2, awvalid_2, awburst_2, awlen_2,
    input  awready_2,
    output wdata_2, wstrb_2, wlast_2, wvalid_2,
    input  wready_2,
    output bready_2,
    input  bresp_2, bvalid_2
  );
endinterface

// File: rtl/bus_arbiter_pmem_port.sv
// rtl/bus_arbiter_pmem_port.sv - word-wide memory port: async read, byte-masked write per cycle
module bus_arbiter_pmem_port
  import bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] rd_addr,
  output logic [63:0] rd_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb
);

  logic [63:0] mem [2**MEM_WORDS_LOG2];

  // Byte offset and the bits above the implemented depth do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:MEM_WORDS_LOG2+3], rd_addr[2:0],
                              wr_addr[31:MEM_WORDS_LOG2+3], wr_addr[2:0]};

  assign rd_data = mem[rd_addr[MEM_WORDS_LOG2+2:3]];

  // Byte-masked write: only lanes with their strobe set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr[MEM_WORDS_LOG2+2:3]][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter (fetch read-only, load/store read-write) onto one memory
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus,
  output logic          inst_update,
  output logic          mem_finish
);

  state_t      state, state_d;
  logic [31:0] addr, addr_d;
  logic [7:0]  len, len_d;
  logic [7:0]  cnt, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        inst_d, fin_d;

  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [31:0] next_addr;
  logic        last_beat;
  logic        rready_sel;

  // Burst type and size are fixed (INCR, 8-byte beats) so these fields carry no information.
  logic unused_bus_fields;
  assign unused_bus_fields = ^{bus.arburst_1, bus.arsize_1, bus.arburst_2,
                               bus.arsize_2, bus.awburst_2};

  assign next_addr  = addr + 32'(BEAT_BYTES);
  assign last_beat  = (cnt == len);
  assign rready_sel = (state == RD1) ? bus.rready_1 : bus.rready_2;

  assign bus.rvalid_1 = (state == RD1);
  assign bus.rvalid_2 = (state == RD2);
  assign bus.rlast_1  = (state == RD1) && last_beat;
  assign bus.rlast_2  = (state == RD2) && last_beat;
  assign bus.rdata_1  = (state == RD1) ? rdata_q : 64'd0;
  assign bus.rdata_2  = (state == RD2) ? rdata_q : 64'd0;
  assign bus.rresp_1  = OKAY;
  assign bus.rresp_2  = OKAY;
  assign bus.bresp_2  = OKAY;

  bus_arbiter_pmem_port u_pmem_port (
    .clk     (clk),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (bus.wdata_2),
    .wr_strb (bus.wstrb_2)
  );

  // Next-state, datapath updates, memory requests and channel readys.
  always_comb begin
    state_d       = state;
    addr_d        = addr;
    len_d         = len;
    cnt_d         = cnt;
    rdata_d       = rdata_q;
    inst_d        = 1'b0;
    fin_d         = 1'b0;
    rd_addr       = addr;
    wr_en         = 1'b0;
    bus.arready_1 = 1'b0;
    bus.arready_2 = 1'b0;
    bus.awready_2 = 1'b0;
    bus.wready_2  = 1'b0;
    bus.bvalid_2  = 1'b0;
    case (state)
      IDLE: begin
        // Readys are gated by rst so nothing is offered while reset is held.
        if (rst) begin
          bus.awready_2 = bus.awvalid_2;
          bus.arready_2 = bus.arvalid_2 & ~bus.awvalid_2;
          bus.arready_1 = bus.arvalid_1 & ~bus.arvalid_2 & ~bus.awvalid_2;
          if (bus.awvalid_2) begin
            addr_d  = align_beat(bus.awaddr_2);
            state_d = WDATA;
          end else if (bus.arvalid_2) begin
            rd_addr = align_beat(bus.araddr_2);
            addr_d  = rd_addr;
            len_d   = bus.arlen_2;
            cnt_d   = 8'd0;
            rdata_d = rd_data;
            state_d = RD2;
          end else if (bus.arvalid_1) begin
            rd_addr = align_beat(bus.araddr_1);
            addr_d  = rd_addr;
            len_d   = bus.arlen_1;
            cnt_d   = 8'd0;
            rdata_d = rd_data;
            state_d = RD1;
          end
        end
      end
      RD1, RD2: begin
        if (rready_sel) begin
          addr_d = next_addr;
          if (last_beat) begin
            state_d = IDLE;
            inst_d  = (state == RD1);
            fin_d   = (state == RD2);
          end else begin
            cnt_d   = cnt + 8'd1;
            rd_addr = next_addr;
            rdata_d = rd_data;
          end
        end
      end
      WDATA: begin
        bus.wready_2 = 1'b1;
        if (bus.wvalid_2) begin
          wr_en  = 1'b1;
          addr_d = next_addr;
          if (bus.wlast_2) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        bus.bvalid_2 = 1'b1;
        if (bus.bready_2) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= 32'd0;
      len         <= 8'd0;
      cnt         <= 8'd0;
      rdata_q     <= 64'd0;
      inst_update <= 1'b0;
      mem_finish  <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      len         <= len_d;
      cnt         <= cnt_d;
      rdata_q     <= rdata_d;
      inst_update <= inst_d;
      mem_finish  <= fin_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic inst_update;
  logic mem_finish;
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] WORD_A     = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] WORD_B     = 64'hFFEE_DDCC_BBAA_9988;
  localparam logic [63:0] WORD_W     = 64'h1122_3344_5566_7788;
  localparam logic [63:0] WORD_AFTER = 64'hFFEE_DDCC_5566_7788;

  logic [63:0] wbuf  [4];
  logic [63:0] burst [4];

  bus_arbiter_if bus();

  bus_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inst_update (inst_update),
    .mem_finish  (mem_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input int n, input logic [7:0] strb);
    bus.awaddr_2  = a;
    bus.awlen_2   = 8'(n - 1);
    bus.awvalid_2 = 1'b1;
    #1;
    chk1("awready_2", bus.awready_2, 1'b1);
    step;
    bus.awvalid_2 = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk1("wready_2", bus.wready_2, 1'b1);
      bus.wdata_2  = wbuf[i];
      bus.wstrb_2  = strb;
      bus.wlast_2  = (i == n - 1);
      bus.wvalid_2 = 1'b1;
      step;
    end
    bus.wvalid_2 = 1'b0;
    bus.wlast_2  = 1'b0;
    #1;
    chk1("bvalid_2", bus.bvalid_2, 1'b1);
    chk("bresp_2", 64'(bus.bresp_2), 64'd0);
    chk1("wready_2_in_wresp", bus.wready_2, 1'b0);
    bus.bready_2 = 1'b1;
    step;
    bus.bready_2 = 1'b0;
    #1;
    chk1("mem_finish_after_b", mem_finish, 1'b1);
    chk1("bvalid_2_after_b", bus.bvalid_2, 1'b0);
  endtask

  initial begin
    burst[0] = 64'hC0DE_0000_0000_0100;
    burst[1] = 64'hC0DE_0000_0000_0108;
    burst[2] = 64'hC0DE_0000_0000_0110;
    burst[3] = 64'hC0DE_0000_0000_0118;

    rst           = 1'b0;
    bus.araddr_1  = 32'd0;  bus.arvalid_1 = 1'b0; bus.arburst_1 = 2'b01;
    bus.arlen_1   = 8'd0;   bus.arsize_1  = 3'd3; bus.rready_1  = 1'b0;
    bus.araddr_2  = 32'd0;  bus.arvalid_2 = 1'b0; bus.arburst_2 = 2'b10;
    bus.arlen_2   = 8'd0;   bus.arsize_2  = 3'd2; bus.rready_2  = 1'b0;
    bus.awaddr_2  = 32'd0;  bus.awvalid_2 = 1'b0; bus.awburst_2 = 2'b00;
    bus.awlen_2   = 8'd0;   bus.wdata_2   = 64'd0; bus.wstrb_2  = 8'd0;
    bus.wlast_2   = 1'b0;   bus.wvalid_2  = 1'b0; bus.bready_2  = 1'b0;

    // reset state
    step;
    step;
    chk1("reset_arready_1", bus.arready_1, 1'b0);
    chk1("reset_rvalid_1", bus.rvalid_1, 1'b0);
    chk1("reset_rvalid_2", bus.rvalid_2, 1'b0);
    chk1("reset_wready_2", bus.wready_2, 1'b0);
    chk1("reset_bvalid_2", bus.bvalid_2, 1'b0);
    chk("reset_rdata_1", bus.rdata_1, 64'd0);
    chk1("reset_inst_update", inst_update, 1'b0);
    chk1("reset_mem_finish", mem_finish, 1'b0);
    rst = 1'b1;
    step;

    // preload memory through master 2 writes
    wbuf[0] = WORD_A;
    do_write(32'h8000_0000, 1, 8'hFF);
    wbuf[0] = WORD_B;
    do_write(32'h8000_1000, 1, 8'hFF);
    for (int i = 0; i < 4; i++) wbuf[i] = burst[i];
    do_write(32'h8000_0100, 4, 8'hFF);

    // master 1 single fetch from an unaligned address
    bus.araddr_1  = 32'h8000_0004;
    bus.arlen_1   = 8'd0;
    bus.rready_1  = 1'b1;
    bus.arvalid_1 = 1'b1;
    #1;
    chk1("t1_arready_1", bus.arready_1, 1'b1);
    step;
    bus.arvalid_1 = 1'b0;
    #1;
    chk1("t1_rvalid_1", bus.rvalid_1, 1'b1);
    chk1("t1_rlast_1", bus.rlast_1, 1'b1);
    chk("t1_rdata_1", bus.rdata_1, WORD_A);
    chk("t1_rresp_1", 64'(bus.rresp_1), 64'd0);
    chk1("t1_inst_update_early", inst_update, 1'b0);
    step;
    chk1("t1_inst_update", inst_update, 1'b1);
    chk1("t1_rvalid_1_done", bus.rvalid_1, 1'b0);
    chk("t1_rdata_1_zero", bus.rdata_1, 64'd0);
    step;
    chk1("t1_inst_update_once", inst_update, 1'b0);

    // both readers at once: master 2 wins, master 1 waits
    bus.araddr_1  = 32'h8000_1000;
    bus.araddr_2  = 32'h8000_0000;
    bus.arlen_2   = 8'd0;
    bus.rready_2  = 1'b1;
    bus.arvalid_1 = 1'b1;
    bus.arvalid_2 = 1'b1;
    #1;
    chk1("t2_arready_2", bus.arready_2, 1'b1);
    chk1("t2_arready_1_lose", bus.arready_1, 1'b0);
    step;
    bus.arvalid_2 = 1'b0;
    #1;
    chk1("t2_rvalid_2", bus.rvalid_2, 1'b1);
    chk("t2_rdata_2", bus.rdata_2, WORD_A);
    chk1("t2_arready_1_busy", bus.arready_1, 1'b0);
    step;
    chk1("t2_mem_finish", mem_finish, 1'b1);
    chk1("t2_arready_1_grant", bus.arready_1, 1'b1);
    step;
    bus.arvalid_1 = 1'b0;
    #1;
    chk1("t2_rvalid_1", bus.rvalid_1, 1'b1);
    chk("t2_rdata_1", bus.rdata_1, WORD_B);
    step;
    chk1("t2_inst_update", inst_update, 1'b1);
    chk1("t2_mem_finish_clear", mem_finish, 1'b0);

    // write beats read on master 2; masked write of the low four bytes
    bus.awaddr_2  = 32'h8000_1000;
    bus.awlen_2   = 8'd0;
    bus.awvalid_2 = 1'b1;
    bus.araddr_2  = 32'h8000_1000;
    bus.arlen_2   = 8'd0;
    bus.arvalid_2 = 1'b1;
    #1;
    chk1("t3_awready_2", bus.awready_2, 1'b1);
    chk1("t3_arready_2_lose", bus.arready_2, 1'b0);
    step;
    bus.awvalid_2 = 1'b0;
    #1;
    chk1("t3_wready_2", bus.wready_2, 1'b1);
    chk1("t3_arready_2_busy", bus.arready_2, 1'b0);
    bus.wdata_2  = WORD_W;
    bus.wstrb_2  = 8'h0F;
    bus.wlast_2  = 1'b1;
    bus.wvalid_2 = 1'b1;
    step;
    bus.wvalid_2 = 1'b0;
    bus.wlast_2  = 1'b0;
    #1;
    chk1("t3_bvalid_2", bus.bvalid_2, 1'b1);
    bus.bready_2 = 1'b1;
    step;
    bus.bready_2 = 1'b0;
    #1;
    chk1("t3_mem_finish_b", mem_finish, 1'b1);
    chk1("t3_arready_2_grant", bus.arready_2, 1'b1);
    step;
    bus.arvalid_2 = 1'b0;
    #1;
    chk1("t3_rvalid_2", bus.rvalid_2, 1'b1);
    chk("t3_rdata_2_masked", bus.rdata_2, WORD_AFTER);
    step;
    chk1("t3_mem_finish_r", mem_finish, 1'b1);

    // four-beat burst with rready toggling
    bus.araddr_2  = 32'h8000_0100;
    bus.arlen_2   = 8'd3;
    bus.rready_2  = 1'b0;
    bus.arvalid_2 = 1'b1;
    #1;
    chk1("t4_arready_2", bus.arready_2, 1'b1);
    step;
    bus.arvalid_2 = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("t4_rvalid_2", bus.rvalid_2, 1'b1);
      chk("t4_rdata_2", bus.rdata_2, burst[i]);
      chk1("t4_rlast_2", bus.rlast_2, (i == 3));
      step;
      chk("t4_rdata_2_held", bus.rdata_2, burst[i]);
      chk1("t4_rlast_2_held", bus.rlast_2, (i == 3));
      bus.rready_2 = 1'b1;
      step;
      bus.rready_2 = 1'b0;
      #1;
      chk1("t4_mem_finish", mem_finish, (i == 3));
    end
    chk1("t4_rvalid_2_done", bus.rvalid_2, 1'b0);

    // reset in the middle of a fetch beat
    bus.araddr_1  = 32'h8000_0000;
    bus.arlen_1   = 8'd0;
    bus.rready_1  = 1'b0;
    bus.arvalid_1 = 1'b1;
    step;
    bus.arvalid_1 = 1'b0;
    #1;
    chk1("t5_rvalid_1_before", bus.rvalid_1, 1'b1);
    #1;
    rst = 1'b0;
    bus.arvalid_1 = 1'b1;
    #1;
    chk1("t5_rvalid_1_reset", bus.rvalid_1, 1'b0);
    chk("t5_rdata_1_reset", bus.rdata_1, 64'd0);
    chk1("t5_rlast_1_reset", bus.rlast_1, 1'b0);
    chk1("t5_arready_1_reset", bus.arready_1, 1'b0);
    bus.arvalid_1 = 1'b0;
    step;
    step;
    chk1("t5_inst_update_reset", inst_update, 1'b0);
    rst = 1'b1;
    bus.araddr_1  = 32'h8000_010C;
    bus.rready_1  = 1'b1;
    bus.arvalid_1 = 1'b1;
    #1;
    chk1("t5_arready_1", bus.arready_1, 1'b1);
    step;
    bus.arvalid_1 = 1'b0;
    #1;
    chk("t5_rdata_1", bus.rdata_1, burst[1]);
    step;
    chk1("t5_inst_update", inst_update, 1'b1);
    step;
    chk1("t5_inst_update_once", inst_update, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
